memc_deskew: RTL

- Output-side counterpart of the B-operand skew buffer.
- Receives the diagonally skewed result stream leaving the DIM x DIM systolic MAC array. Lane i of row r arrives i enable-cycles after lane 0 of the same row.
- Realigns the stream into full, aligned C rows and presents one row per pulse to the result writeback logic.
- Tracks tile progress with a small FSM and signals tile completion.

---
 rtl/memc_deskew.sv | 90 +++++++++
 1 files changed

// File: rtl/memc_deskew.sv
// Output deskew for the systolic MAC array: realigns diagonally skewed result
// lanes into full C rows and tracks tile progress, pulsing done on the last row.
module memc_deskew #(
  parameter int unsigned BITS_C = 24,
  parameter int unsigned DIM    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          start,
  input  logic [DIM-1:0][BITS_C-1:0]    Cin,
  output logic [DIM-1:0][BITS_C-1:0]    Cout,
  output logic                          out_valid,
  output logic [$clog2(DIM)-1:0]        row_idx,
  output logic                          done
);

  localparam int unsigned CW = $clog2(2*DIM);
  localparam int unsigned RW = $clog2(DIM);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       r_state;
  logic [CW-1:0]                r_cnt;
  logic [DIM-1:0][BITS_C-1:0]   w_tap;

  // Lane i is delayed DIM-1-i en-edges so every lane of a row lines up at Cout.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    if (i == DIM-1) begin : g_direct
      assign w_tap[i] = Cin[i];
    end else begin : g_delay
      localparam int unsigned NS = DIM - 1 - i;
      logic [BITS_C-1:0] r_sr [NS];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned s = 0; s < NS; s++) r_sr[s] <= '0;
        end else if (en) begin
          r_sr[0] <= Cin[i];
          for (int unsigned s = 1; s < NS; s++) r_sr[s] <= r_sr[s-1];
        end
      end

      assign w_tap[i] = r_sr[NS-1];
    end
  end

  // Tile FSM; cnt counts en-edges since start, rows emerge for cnt in [DIM-1, 2*DIM-2].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      Cout      <= '0;
      out_valid <= 1'b0;
      row_idx   <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (en) begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_cnt   <= CW'(1);
              r_state <= RUN;
            end
          end
          RUN: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt >= CW'(DIM-1)) begin
              Cout      <= w_tap;
              row_idx   <= RW'(r_cnt - CW'(DIM-1));
              out_valid <= 1'b1;
            end
            if (r_cnt == CW'(2*DIM-2)) begin
              done    <= 1'b1;
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
